// File: rtl/mem_dma_master_pkg.sv
// Shared bus definitions for the 64-bit valid/ready memory bus and the DMA master FSM.
package mem_bus_defs;

  localparam int unsigned XLEN = 64;

  localparam logic [7:0] WSTRB_RD = 8'h00;
  localparam logic [7:0] WSTRB_WR = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_GAP,
    ST_WR_REQ,
    ST_WR_GAP,
    ST_FIN
  } dma_state_t;

endpackage

// File: rtl/dma_buf.sv
// Burst staging buffer: DEPTH x W register file, one write port, one async read port.
module dma_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64,
  parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Store one read-back doubleword per accepted read handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_dma_master.sv
// Memory-to-memory copy engine acting as a second initiator on the valid/ready bus.
module mem_dma_master #(
  parameter int unsigned XLEN      = mem_bus_defs::XLEN,
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned LEN_W     = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [XLEN-1:0]  src_addr,
  input  logic [XLEN-1:0]  dst_addr,
  input  logic [LEN_W-1:0] len_dw,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_valid,
  output logic             mem_instr,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [7:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [XLEN-1:0]  mem_rdata
);

  import mem_bus_defs::*;

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(BUF_DEPTH);
  localparam logic [XLEN-1:0]  STEP    = XLEN'(8);

  dma_state_t       r_state, w_state_nx;
  logic [XLEN-1:0]  r_src, w_src_nx;
  logic [XLEN-1:0]  r_dst, w_dst_nx;
  logic [LEN_W-1:0] r_rem, w_rem_nx;
  logic [CNT_W-1:0] r_burst, w_burst_nx;
  logic [CNT_W-1:0] r_wcnt, w_wcnt_nx;
  logic [CNT_W-1:0] r_rcnt, w_rcnt_nx;
  logic             r_err, w_err_nx;
  logic             w_buf_we;
  logic [XLEN-1:0]  w_buf_rdata;
  logic             w_misaligned;

  // Burst length is the smaller of the buffer size and what is left to copy.
  function automatic logic [CNT_W-1:0] burst_of(input logic [LEN_W-1:0] rem);
    return (rem < DEPTH_L) ? CNT_W'(rem) : CNT_W'(BUF_DEPTH);
  endfunction

  assign w_misaligned = (|src_addr[2:0]) | (|dst_addr[2:0]);

  dma_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (XLEN)
  ) u_buf (
    .i_clk   (clk),
    .i_rst_n (resetn),
    .i_we    (w_buf_we),
    .i_waddr (r_wcnt[PTR_W-1:0]),
    .i_wdata (mem_rdata),
    .i_raddr (r_rcnt[PTR_W-1:0]),
    .o_rdata (w_buf_rdata)
  );

  // State, address, length and burst-pointer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_burst <= '0;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_src   <= w_src_nx;
      r_dst   <= w_dst_nx;
      r_rem   <= w_rem_nx;
      r_burst <= w_burst_nx;
      r_wcnt  <= w_wcnt_nx;
      r_rcnt  <= w_rcnt_nx;
      r_err   <= w_err_nx;
    end
  end

  // Next-state and bus outputs; outputs decode registered state only, so reset clears them at once.
  always_comb begin
    w_state_nx = r_state;
    w_src_nx   = r_src;
    w_dst_nx   = r_dst;
    w_rem_nx   = r_rem;
    w_burst_nx = r_burst;
    w_wcnt_nx  = r_wcnt;
    w_rcnt_nx  = r_rcnt;
    w_err_nx   = 1'b0;
    w_buf_we   = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = WSTRB_RD;
    busy       = 1'b1;
    done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (w_misaligned) begin
            w_err_nx = 1'b1;
          end else begin
            w_src_nx   = src_addr;
            w_dst_nx   = dst_addr;
            w_rem_nx   = len_dw;
            w_burst_nx = burst_of(len_dw);
            w_wcnt_nx  = '0;
            w_rcnt_nx  = '0;
            w_state_nx = (len_dw == '0) ? ST_FIN : ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = r_src;
        if (mem_ready) begin
          w_buf_we   = 1'b1;
          w_src_nx   = r_src + STEP;
          w_wcnt_nx  = r_wcnt + 1'b1;
          w_state_nx = ST_RD_GAP;
        end
      end
      ST_RD_GAP: begin
        if (r_wcnt != r_burst) begin
          w_state_nx = ST_RD_REQ;
        end else begin
          w_rcnt_nx  = '0;
          w_state_nx = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = r_dst;
        mem_wdata = w_buf_rdata;
        mem_wstrb = WSTRB_WR;
        if (mem_ready) begin
          w_dst_nx   = r_dst + STEP;
          w_rem_nx   = (r_rem != '0) ? r_rem - 1'b1 : r_rem;
          w_rcnt_nx  = r_rcnt + 1'b1;
          w_state_nx = ST_WR_GAP;
        end
      end
      ST_WR_GAP: begin
        if (r_rcnt != r_burst) begin
          w_state_nx = ST_WR_REQ;
        end else if (r_rem != '0) begin
          w_burst_nx = burst_of(r_rem);
          w_wcnt_nx  = '0;
          w_state_nx = ST_RD_REQ;
        end else begin
          w_state_nx = ST_FIN;
        end
      end
      ST_FIN: begin
        done       = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  assign err       = r_err;
  assign mem_instr = 1'b0;

endmodule
